regfile_wr_arb: RTL and testbench

REGFILE_WR_ARB -- requirements
Module: regfile_wr_arb

---
 rtl/regfile_ctrl_pkg.sv | 13 +
 rtl/rr_arb4.sv | 29 ++
 rtl/regfile_wr_arb.sv | 143 ++++++++++++++
 tb/tb_regfile_wr_arb.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_ctrl_pkg.sv
// Shared definitions for the register-file write arbiter.
//   state_e : controller state encoding (INIT sweeps the file, RUN serves requesters)
//   NumReq  : number of write requesters competing for the single write port
package regfile_ctrl_pkg;

  localparam int unsigned NumReq = 4;

  typedef enum logic {
    StInit = 1'b0,
    StRun  = 1'b1
  } state_e;

endpackage

// File: rtl/rr_arb4.sv
// Four-way combinational round-robin arbiter.
//   req : per-requester request bits
//   ptr : requester with the highest priority this cycle
//   gnt : one-hot grant, all zero when nothing is requested
module rr_arb4
  import regfile_ctrl_pkg::*;
(
  input  logic [NumReq-1:0] req,
  input  logic [1:0]        ptr,
  output logic [NumReq-1:0] gnt
);

  always_comb begin
    logic       found;
    logic [1:0] idx;
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    // Walk from ptr upward, wrapping mod 4; first asserted request wins.
    for (int k = 0; k < NumReq; k++) begin
      idx = ptr + 2'(k);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wr_arb.sv
// Register-file write-port controller.
// After reset (or CLEAR) it sweeps indices lo..hi writing init_val, one entry per
// cycle, then arbitrates four write requesters round-robin onto the single
// registered write port.
//   CLK, RST_N     : clock, asynchronous active-low reset
//   CLEAR          : restart initialisation (honoured only in RUN)
//   REQ_VALID/ADDR/DATA, REQ_READY : four packed requesters, one-hot grant
//   WE, ADDR_IN, D_IN : registered register-file write port
//   INIT_DONE      : high while in RUN
//   ERR_OOR        : sticky, set when a granted address falls outside [lo,hi]
module regfile_wr_arb
  import regfile_ctrl_pkg::*;
#(
  parameter int unsigned            addr_width = 1,
  parameter int unsigned            data_width = 1,
  parameter int unsigned            lo         = 0,
  parameter int unsigned            hi         = 1,
  parameter logic [data_width-1:0]  init_val   = '0
) (
  input  logic                           CLK,
  input  logic                           RST_N,
  input  logic                           CLEAR,
  input  logic [NumReq-1:0]              REQ_VALID,
  input  logic [NumReq*addr_width-1:0]   REQ_ADDR,
  input  logic [NumReq*data_width-1:0]   REQ_DATA,
  output logic [NumReq-1:0]              REQ_READY,
  output logic                           WE,
  output logic [addr_width-1:0]          ADDR_IN,
  output logic [data_width-1:0]          D_IN,
  output logic                           INIT_DONE,
  output logic                           ERR_OOR
);

  localparam logic [addr_width-1:0] LoIdx = addr_width'(lo);
  localparam logic [addr_width-1:0] HiIdx = addr_width'(hi);

  state_e                  state_q, state_d;
  logic [addr_width-1:0]   cnt_q, cnt_d;
  logic [1:0]              ptr_q, ptr_d;
  logic                    we_q, we_d;
  logic [addr_width-1:0]   addr_q, addr_d;
  logic [data_width-1:0]   data_q, data_d;
  logic                    err_q, err_d;

  logic [NumReq-1:0]       gnt;
  logic                    grant_en;
  logic [1:0]              gnt_idx;
  logic [addr_width-1:0]   sel_addr;
  logic [data_width-1:0]   sel_data;
  int unsigned             sel_addr_ext;
  logic                    in_range;

  rr_arb4 u_arb (
    .req (REQ_VALID),
    .ptr (ptr_q),
    .gnt (gnt)
  );

  // CLEAR pre-empts arbitration so no request is consumed on the restart cycle.
  assign grant_en  = (state_q == StRun) && !CLEAR;
  assign REQ_READY = grant_en ? gnt : '0;

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (gnt[i]) gnt_idx = 2'(i);
    end
  end

  assign sel_addr     = REQ_ADDR[gnt_idx*addr_width +: addr_width];
  assign sel_data     = REQ_DATA[gnt_idx*data_width +: data_width];
  assign sel_addr_ext = 32'(sel_addr);
  // Offset by one so neither bound folds to a constant compare when lo=0 or hi=max.
  assign in_range     = (sel_addr_ext + 1 > lo) && (sel_addr_ext < hi + 1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    err_d   = err_q;
    unique case (state_q)
      StInit: begin
        // CLEAR is ignored here; the sweep always runs to completion.
        we_d   = 1'b1;
        addr_d = cnt_q;
        data_d = init_val;
        if (cnt_q == HiIdx) begin
          state_d = StRun;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRun: begin
        if (CLEAR) begin
          state_d = StInit;
          cnt_d   = LoIdx;
          err_d   = 1'b0;
        end else if (|gnt) begin
          ptr_d = gnt_idx + 2'd1;
          if (in_range) begin
            we_d   = 1'b1;
            addr_d = sel_addr;
            data_d = sel_data;
          end else begin
            // Out-of-range writes are consumed but dropped; port holds last values.
            err_d = 1'b1;
          end
        end
      end
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= StInit;
      cnt_q   <= LoIdx;
      ptr_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign WE        = we_q;
  assign ADDR_IN   = addr_q;
  assign D_IN      = data_q;
  assign INIT_DONE = (state_q == StRun);
  assign ERR_OOR   = err_q;

endmodule

// File: tb/tb_regfile_wr_arb.sv
// Drives two instances (full range 0..7 and narrow range 2..5) with identical
// stimulus and compares every output each cycle against a behavioural model.
module tb_regfile_wr_arb;

  localparam int unsigned AW = 3;
  localparam int unsigned DW = 8;

  logic            CLK;
  logic            RST_N;
  logic            CLEAR;
  logic [3:0]      REQ_VALID;
  logic [4*AW-1:0] REQ_ADDR;
  logic [4*DW-1:0] REQ_DATA;

  logic [3:0]      ready  [2];
  logic            we     [2];
  logic [AW-1:0]   addr_o [2];
  logic [DW-1:0]   data_o [2];
  logic            done   [2];
  logic            err    [2];

  int n_tests;
  int n_fail;

  // Model state per instance
  int m_lo [2] = '{0, 2};
  int m_hi [2] = '{7, 5};
  bit m_init [2];
  int m_idx  [2];
  int m_ptr  [2];
  bit m_we   [2];
  int m_addr [2];
  int m_data [2];
  bit m_err  [2];

  regfile_wr_arb #(
    .addr_width (AW), .data_width (DW), .lo (0), .hi (7), .init_val (8'hAA)
  ) u_dut_full (
    .CLK (CLK), .RST_N (RST_N), .CLEAR (CLEAR),
    .REQ_VALID (REQ_VALID), .REQ_ADDR (REQ_ADDR), .REQ_DATA (REQ_DATA),
    .REQ_READY (ready[0]), .WE (we[0]), .ADDR_IN (addr_o[0]), .D_IN (data_o[0]),
    .INIT_DONE (done[0]), .ERR_OOR (err[0])
  );

  regfile_wr_arb #(
    .addr_width (AW), .data_width (DW), .lo (2), .hi (5), .init_val (8'hAA)
  ) u_dut_narrow (
    .CLK (CLK), .RST_N (RST_N), .CLEAR (CLEAR),
    .REQ_VALID (REQ_VALID), .REQ_ADDR (REQ_ADDR), .REQ_DATA (REQ_DATA),
    .REQ_READY (ready[1]), .WE (we[1]), .ADDR_IN (addr_o[1]), .D_IN (data_o[1]),
    .INIT_DONE (done[1]), .ERR_OOR (err[1])
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int pick(int m, logic [3:0] v);
    for (int k = 0; k < 4; k++) begin
      int j;
      j = (m_ptr[m] + k) % 4;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_ready(int m, logic [3:0] v, logic clr);
    int g;
    if (m_init[m] || clr) return 4'b0000;
    g = pick(m, v);
    if (g < 0) return 4'b0000;
    return 4'(1 << g);
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_init[m] = 1'b1;
      m_idx[m]  = m_lo[m];
      m_ptr[m]  = 0;
      m_we[m]   = 1'b0;
      m_addr[m] = 0;
      m_data[m] = 0;
      m_err[m]  = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int m = 0; m < 2; m++) begin
      if (m_init[m]) begin
        m_we[m]   = 1'b1;
        m_addr[m] = m_idx[m];
        m_data[m] = 'hAA;
        if (m_idx[m] == m_hi[m]) m_init[m] = 1'b0;
        else m_idx[m]++;
      end else if (CLEAR) begin
        m_init[m] = 1'b1;
        m_idx[m]  = m_lo[m];
        m_err[m]  = 1'b0;
        m_we[m]   = 1'b0;
      end else begin
        int g;
        g = pick(m, REQ_VALID);
        m_we[m] = 1'b0;
        if (g >= 0) begin
          int a;
          a = int'((REQ_ADDR >> (AW * g)) & 7);
          m_ptr[m] = (g + 1) % 4;
          if (a >= m_lo[m] && a <= m_hi[m]) begin
            m_we[m]   = 1'b1;
            m_addr[m] = a;
            m_data[m] = int'((REQ_DATA >> (DW * g)) & 8'hFF);
          end else begin
            m_err[m] = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic check_all();
    for (int m = 0; m < 2; m++) begin
      check_eq($sformatf("ready%0d", m), 32'(ready[m]), 32'(exp_ready(m, REQ_VALID, CLEAR)));
      check_eq($sformatf("we%0d", m), 32'(we[m]), 32'(m_we[m]));
      check_eq($sformatf("addr%0d", m), 32'(addr_o[m]), 32'(m_addr[m]));
      check_eq($sformatf("data%0d", m), 32'(data_o[m]), 32'(m_data[m]));
      check_eq($sformatf("done%0d", m), 32'(done[m]), 32'(!m_init[m]));
      check_eq($sformatf("err%0d", m), 32'(err[m]), 32'(m_err[m]));
    end
  endtask

  // One clock: drive on negedge, check 1ns later, advance the model at posedge.
  task automatic run_cycle(input logic rst_v, input logic clr, input logic [3:0] v,
                           input logic [4*AW-1:0] a, input logic [4*DW-1:0] d);
    @(negedge CLK);
    RST_N     = rst_v;
    CLEAR     = clr;
    REQ_VALID = v;
    REQ_ADDR  = a;
    REQ_DATA  = d;
    if (!rst_v) model_reset();
    #1;
    check_all();
    @(posedge CLK);
    if (RST_N) model_step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) run_cycle(1'b1, 1'b0, 4'b0000, '0, '0);
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    RST_N     = 1'b0;
    CLEAR     = 1'b0;
    REQ_VALID = '0;
    REQ_ADDR  = '0;
    REQ_DATA  = '0;
    model_reset();

    for (int i = 0; i < 3; i++) run_cycle(1'b0, 1'b0, 4'b0000, '0, '0);
    // Partial sweep, then reset with index 4 pending
    idle(4);
    for (int i = 0; i < 2; i++) run_cycle(1'b0, 1'b0, 4'b1111, '0, '0);
    // Full sweep from 0, with requests held off until RUN
    idle(10);

    // All four requesting: rotating grants
    for (int i = 0; i < 6; i++)
      run_cycle(1'b1, 1'b0, 4'b1111, 12'($urandom_range(0, 4095)), $urandom);
    idle(1);

    // Requester 2 alone, addr 5, data 3C
    run_cycle(1'b1, 1'b0, 4'b0100, 12'(5 << 6), 32'(8'h3C << 16));
    idle(2);

    // Addr 7: legal for full instance, out of range for narrow one
    run_cycle(1'b1, 1'b0, 4'b0001, 12'd7, 32'h0000_0011);
    idle(2);

    // CLEAR with requester 0 pending, then hold it through the sweep
    run_cycle(1'b1, 1'b1, 4'b0001, 12'd3, 32'h0000_0055);
    for (int i = 0; i < 12; i++) run_cycle(1'b1, 1'b0, 4'b0001, 12'd3, 32'h0000_0055);

    // CLEAR during INIT must be ignored
    run_cycle(1'b1, 1'b1, 4'b0000, '0, '0);
    for (int i = 0; i < 3; i++) run_cycle(1'b1, 1'b1, 4'b0011, 12'd2, 32'h0);
    idle(10);

    for (int i = 0; i < 400; i++) begin
      logic rst_v;
      logic clr;
      rst_v = ($urandom_range(0, 99) != 0);
      clr   = ($urandom_range(0, 19) == 0);
      run_cycle(rst_v, clr, 4'($urandom_range(0, 15)), 12'($urandom_range(0, 4095)), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
